// File: rtl/dual_issue_pkg.sv
// Shared instruction-decode definitions for the dual-issue scheduler and decode hazard logic.
package dual_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {CLS_ALU, CLS_MEM, CLS_CTRL} instr_cls_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } dest_t;

  function automatic dest_t dest_reg(input logic [31:0] instr);
    dest_t d;
    d = '{valid: 1'b0, rd: 5'd0};
    case (instr[31:26])
      OP_RTYPE: if (instr[5:0] != FN_JR) d = '{valid: 1'b1, rd: instr[15:11]};
      OP_JAL:   d = '{valid: 1'b1, rd: 5'd31};
      OP_J, OP_BEQ, OP_BNE, OP_SW: d = '{valid: 1'b0, rd: 5'd0};
      default:  d = '{valid: 1'b1, rd: instr[20:16]};
    endcase
    return d;
  endfunction

  function automatic instr_cls_e instr_class(input logic [31:0] instr);
    instr_cls_e c;
    c = CLS_ALU;
    case (instr[31:26])
      OP_LW, OP_SW:               c = CLS_MEM;
      OP_J, OP_JAL, OP_BEQ, OP_BNE: c = CLS_CTRL;
      OP_RTYPE: if (instr[5:0] == FN_JR) c = CLS_CTRL;
      default:                    c = CLS_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_hazard.sv
// Combinational pair-split decision for two adjacent instructions (older in slot 0).
module pair_hazard_check
  import dual_issue_pkg::*;
(
  input  logic [31:0] i_instr0,
  input  logic [31:0] i_instr1,
  output logic        o_split
);

  dest_t      w_d0, w_d1;
  instr_cls_e w_c0, w_c1;
  logic       w_raw, w_waw, w_mem, w_ctrl, w_link, w_e1_jr, w_e1_jal;

  always_comb begin
    w_d0     = dest_reg(i_instr0);
    w_d1     = dest_reg(i_instr1);
    w_c0     = instr_class(i_instr0);
    w_c1     = instr_class(i_instr1);
    w_e1_jr  = (i_instr1[31:26] == OP_RTYPE) && (i_instr1[5:0] == FN_JR);
    w_e1_jal = (i_instr1[31:26] == OP_JAL);
    // $0 writes are architecturally discarded, so they never order a pair
    w_raw    = w_d0.valid && (w_d0.rd != 5'd0) &&
               ((w_d0.rd == i_instr1[25:21]) || (w_d0.rd == i_instr1[20:16]));
    w_waw    = w_d0.valid && w_d1.valid && (w_d0.rd != 5'd0) && (w_d0.rd == w_d1.rd);
    w_mem    = (w_c0 == CLS_MEM) && (w_c1 == CLS_MEM);
    w_ctrl   = (w_c0 == CLS_CTRL);
    w_link   = (w_e1_jr || w_e1_jal) && w_d0.valid && (w_d0.rd == 5'd31);
    o_split  = w_raw || w_waw || w_mem || w_ctrl || w_link;
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Circular instruction queue between dual fetch and decode, issuing one or two oldest entries per cycle.
module dual_issue_scheduler
  import dual_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned PCW   = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [1:0]     in_valid,
  input  logic [IW-1:0]  in_instr0,
  input  logic [IW-1:0]  in_instr1,
  input  logic [PCW-1:0] in_pc0,
  output logic           in_ready,
  input  logic           out_ready,
  output logic [1:0]     out_valid,
  output logic [IW-1:0]  out_instr0,
  output logic [IW-1:0]  out_instr1,
  output logic [PCW-1:0] out_pc0,
  output logic [PCW-1:0] out_pc1,
  output logic [15:0]    dual_cnt,
  output logic [15:0]    single_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IW-1:0]  r_instr [DEPTH];
  logic [PCW-1:0] r_pc    [DEPTH];
  logic [AW-1:0]  r_head, r_tail;
  logic [CW-1:0]  r_count;
  logic [15:0]    r_dual_cnt, r_single_cnt;

  logic [AW-1:0]  w_head1, w_tail1;
  logic [IW-1:0]  w_e0_instr, w_e1_instr;
  logic           w_split;
  logic [1:0]     w_enq_n, w_deq_n;

  assign w_head1    = r_head + AW'(1);
  assign w_tail1    = r_tail + AW'(1);
  assign w_e0_instr = r_instr[r_head];
  assign w_e1_instr = r_instr[w_head1];

  pair_hazard_check u_hazard (
    .i_instr0 (w_e0_instr[31:0]),
    .i_instr1 (w_e1_instr[31:0]),
    .o_split  (w_split)
  );

  always_comb begin
    in_ready     = (r_count <= CW'(DEPTH - 2));
    out_valid[0] = (r_count >= CW'(1));
    out_valid[1] = (r_count >= CW'(2)) && !w_split;
    out_instr0   = w_e0_instr;
    out_instr1   = w_e1_instr;
    out_pc0      = r_pc[r_head];
    out_pc1      = r_pc[w_head1];
    dual_cnt     = r_dual_cnt;
    single_cnt   = r_single_cnt;

    w_enq_n = 2'd0;
    if (in_ready && !flush) begin
      if (in_valid == 2'b11)      w_enq_n = 2'd2;
      else if (in_valid == 2'b01) w_enq_n = 2'd1;
    end
    w_deq_n = 2'd0;
    if (out_ready) w_deq_n = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
  end

  always_ff @(posedge clk) begin
    if (w_enq_n != 2'd0) begin
      r_instr[r_tail] <= in_instr0;
      r_pc[r_tail]    <= in_pc0;
    end
    if (w_enq_n == 2'd2) begin
      r_instr[w_tail1] <= in_instr1;
      r_pc[w_tail1]    <= in_pc0 + PCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_dual_cnt   <= '0;
      r_single_cnt <= '0;
    end else begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + AW'(w_deq_n);
        r_tail  <= r_tail + AW'(w_enq_n);
        r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
      end
      if (out_ready && out_valid == 2'b11) r_dual_cnt   <= r_dual_cnt + 16'd1;
      if (out_ready && out_valid == 2'b01) r_single_cnt <= r_single_cnt + 16'd1;
    end
  end

endmodule
